// File: rtl/amcal3_16bit_shift_mult.sv
// Approximate 16x16 multiplier back end: combines two 3-bit mantissas and
// leading-one positions from an LOD stage into a 32-bit approximate product.
// Three register stages with a single global stall driven by out_ready.
module amcal3_16bit_shift_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  a,
    input  logic [2:0]  b,
    input  logic [3:0]  ashift,
    input  logic [3:0]  bshift,
    input  logic        azero,
    input  logic        bzero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] p
);

    // Stage 1: captured operands
    logic       s1_valid_q, s1_valid_d;
    logic [2:0] s1_a_q, s1_a_d;
    logic [2:0] s1_b_q, s1_b_d;
    logic [3:0] s1_ashift_q, s1_ashift_d;
    logic [3:0] s1_bshift_q, s1_bshift_d;
    logic       s1_zero_q, s1_zero_d;

    // Stage 2: mantissa product and exponent sum
    logic       s2_valid_q, s2_valid_d;
    logic [7:0] s2_prod_q, s2_prod_d;
    logic [4:0] s2_sum_q, s2_sum_d;
    logic       s2_zero_q, s2_zero_d;

    // Stage 3: final product
    logic        out_valid_q, out_valid_d;
    logic [31:0] p_q, p_d;

    logic        advance;
    logic [7:0]  s1_prod;
    logic [4:0]  s1_sum;
    logic [31:0] s2_shifted;

    // Whole pipe freezes only when a result is waiting and not taken.
    assign advance   = !(out_valid_q && !out_ready);
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign p         = p_q;

    // Mantissa product (implicit leading one) and shift sum from stage-1 contents.
    always_comb begin
        s1_prod = {5'd1, s1_a_q} * {5'd1, s1_b_q};
        s1_sum  = {1'b0, s1_ashift_q} + {1'b0, s1_bshift_q};
    end

    // Product is scaled by 2^(sum-6); the right-shift branch truncates.
    always_comb begin
        s2_shifted = 32'd0;
        if (s2_zero_q) begin
            s2_shifted = 32'd0;
        end else if (s2_sum_q >= 5'd6) begin
            s2_shifted = {24'd0, s2_prod_q} << (s2_sum_q - 5'd6);
        end else begin
            s2_shifted = {24'd0, s2_prod_q} >> (5'd6 - s2_sum_q);
        end
    end

    // Next-state: hold everything on stall, otherwise shift the whole pipe by one.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_ashift_d = s1_ashift_q;
        s1_bshift_d = s1_bshift_q;
        s1_zero_d   = s1_zero_q;
        s2_valid_d  = s2_valid_q;
        s2_prod_d   = s2_prod_q;
        s2_sum_d    = s2_sum_q;
        s2_zero_d   = s2_zero_q;
        out_valid_d = out_valid_q;
        p_d         = p_q;
        if (advance) begin
            s1_valid_d  = in_valid;
            s1_a_d      = a;
            s1_b_d      = b;
            s1_ashift_d = ashift;
            s1_bshift_d = bshift;
            s1_zero_d   = azero | bzero;
            s2_valid_d  = s1_valid_q;
            s2_prod_d   = s1_prod;
            s2_sum_d    = s1_sum;
            s2_zero_d   = s1_zero_q;
            out_valid_d = s2_valid_q;
            p_d         = s2_shifted;
        end
    end

    // State registers with synchronous reset; reset wins over any offered transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= 3'd0;
            s1_b_q      <= 3'd0;
            s1_ashift_q <= 4'd0;
            s1_bshift_q <= 4'd0;
            s1_zero_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_prod_q   <= 8'd0;
            s2_sum_q    <= 5'd0;
            s2_zero_q   <= 1'b0;
            out_valid_q <= 1'b0;
            p_q         <= 32'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_ashift_q <= s1_ashift_d;
            s1_bshift_q <= s1_bshift_d;
            s1_zero_q   <= s1_zero_d;
            s2_valid_q  <= s2_valid_d;
            s2_prod_q   <= s2_prod_d;
            s2_sum_q    <= s2_sum_d;
            s2_zero_q   <= s2_zero_d;
            out_valid_q <= out_valid_d;
            p_q         <= p_d;
        end
    end

endmodule

// File: tb/tb_amcal3_16bit_shift_mult.sv
// Directed bench for amcal3_16bit_shift_mult: latency, arithmetic corners,
// stall/throughput streaming and mid-flight reset.
module tb_amcal3_16bit_shift_mult;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [3:0]  ashift;
    logic [3:0]  bshift;
    logic        azero;
    logic        bzero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;

    int n_total = 0;
    int n_pass  = 0;

    amcal3_16bit_shift_mult dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ashift    (ashift),
        .bshift    (bshift),
        .azero     (azero),
        .bzero     (bzero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: floor((8+a)*(8+b)*2^(sa+sb)/64), computed in 64-bit.
    function automatic logic [31:0] model(input logic [2:0] ma, input logic [3:0] sa,
                                          input logic [2:0] mb, input logic [3:0] sb,
                                          input logic za, input logic zb);
        longint unsigned m;
        if (za || zb) return 32'd0;
        m = 64'(8 + int'(ma)) * 64'(8 + int'(mb));
        m = m << (int'(sa) + int'(sb));
        return 32'(m >> 6);
    endfunction

    task automatic drive(input logic [2:0] ma, input logic [3:0] sa, input logic [2:0] mb,
                         input logic [3:0] sb, input logic za, input logic zb);
        a = ma; ashift = sa; b = mb; bshift = sb; azero = za; bzero = zb;
    endtask

    // One operand set into an empty pipe; result must appear after exactly three edges.
    task automatic run_single(input logic [2:0] ma, input logic [3:0] sa, input logic [2:0] mb,
                              input logic [3:0] sb, input logic za, input logic zb,
                              input logic [31:0] exp, input string tag);
        drive(ma, sa, mb, sb, za, zb);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        drive(~ma, ~sa, ~mb, ~sb, ~za, ~zb);
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        step();
        check({tag, "_lat2"}, 32'(out_valid), 32'd0);
        step();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_p"}, p, exp);
        step();
        check({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    logic [2:0] va [8] = '{3'd7, 3'd0, 3'd4, 3'd1, 3'd2, 3'd7, 3'd5, 3'd3};
    logic [3:0] sa [8] = '{4'd7, 4'd0, 4'd1, 4'd2, 4'd10, 4'd15, 4'd3, 4'd0};
    logic [2:0] vb [8] = '{3'd0, 3'd0, 3'd4, 3'd3, 3'd5, 3'd7, 3'd6, 3'd1};
    logic [3:0] sb [8] = '{4'd8, 4'd0, 4'd1, 4'd1, 4'd4, 4'd15, 4'd9, 4'd2};
    logic       za [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_q[$];
        logic        v1, v2, v3, m_stall, held;
        logic [31:0] held_p;
        int          sent, got;

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        drive(3'd7, 4'd7, 3'd0, 4'd8, 1'b0, 1'b0);
        repeat (2) step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_p", p, 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        step();
        check("rst_no_emit", 32'(out_valid), 32'd0);

        run_single(3'd7, 4'd7, 3'd0, 4'd8, 1'b0, 1'b0, 32'd61440,      "ff_x_100");
        run_single(3'd4, 4'd1, 3'd4, 4'd1, 1'b0, 1'b0, 32'd9,          "3x3");
        run_single(3'd0, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0, 32'd1,          "1x1");
        run_single(3'd7, 4'd15, 3'd7, 4'd15, 1'b0, 1'b0, 32'hE1000000, "max");
        run_single(3'd5, 4'd3, 3'd2, 4'd9, 1'b1, 1'b0, 32'd0,          "azero");
        run_single(3'd6, 4'd12, 3'd1, 4'd2, 1'b0, 1'b1, 32'd0,         "bzero");
        run_single(3'd1, 4'd2, 3'd3, 4'd1, 1'b0, 1'b0, 32'd12,         "trunc");
        run_single(3'd2, 4'd10, 3'd5, 4'd4, 1'b0, 1'b0, 32'd33280,     "mid");

        // Streaming with out_ready pattern 1,0,0,1 against a valid-bit pipeline model.
        v1 = 0; v2 = 0; v3 = 0; held = 0; held_p = '0; sent = 0; got = 0;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (sent < 8) begin
                in_valid = 1'b1;
                drive(va[sent], sa[sent], vb[sent], sb[sent], za[sent], 1'b0);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            m_stall = v3 && !out_ready;
            check("stream_out_valid", 32'(out_valid), 32'(v3));
            check("stream_in_ready", 32'(in_ready), 32'(!m_stall));
            if (held) check("stall_p_stable", p, held_p);
            held   = m_stall;
            held_p = p;
            if (v3 && out_ready) begin
                if (exp_q.size() == 0) check("stream_extra", 32'd1, 32'd0);
                else check("stream_p", p, exp_q.pop_front());
                got++;
            end
            if (in_valid && !m_stall) begin
                exp_q.push_back(model(va[sent], sa[sent], vb[sent], sb[sent], za[sent], 1'b0));
                sent++;
            end
            if (!m_stall) begin
                v3 = v2; v2 = v1; v1 = in_valid;
            end
            step();
        end
        check("stream_count", 32'(got), 32'd8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        // Reset with sets in flight; the set offered alongside reset must also vanish.
        drive(3'd1, 4'd3, 3'd2, 4'd4, 1'b0, 1'b0);
        in_valid = 1'b1;
        step();
        drive(3'd3, 4'd5, 3'd4, 4'd6, 1'b0, 1'b0);
        step();
        drive(3'd5, 4'd7, 3'd6, 4'd8, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_p", p, 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("midrst_no_emit", 32'(out_valid), 32'd0);
            step();
        end
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        run_single(3'd4, 4'd1, 3'd4, 4'd1, 1'b0, 1'b0, 32'd9, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
